// File: rtl/stepper_pkg.sv
// Coil phase patterns, phase index lookup and fault codes shared by the
// stepper drive and its monitor.
package stepper_pkg;

    localparam logic [3:0] PH_0     = 4'b1000;
    localparam logic [3:0] PH_1     = 4'b0011;
    localparam logic [3:0] PH_2     = 4'b0010;
    localparam logic [3:0] PH_3     = 4'b0110;
    localparam logic [3:0] PH_4     = 4'b0100;
    localparam logic [3:0] PH_5     = 4'b1100;
    localparam logic [3:0] PH_6     = 4'b0001;
    localparam logic [3:0] PH_7     = 4'b1001;
    localparam logic [3:0] PAT_IDLE = 4'b0000;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_SKIP    = 2'b10;

    typedef enum logic [1:0] {
        PK_NONE,
        PK_IDLE,
        PK_LEGAL,
        PK_ILLEGAL
    } phase_kind_e;

    typedef struct packed {
        phase_kind_e kind;
        logic [2:0]  idx;
    } phase_t;

    localparam phase_t PHASE_NONE = '{kind: PK_NONE, idx: 3'd0};

    function automatic phase_t phase_lookup(input logic [3:0] pat);
        phase_t r;
        r.kind = PK_LEGAL;
        r.idx  = 3'd0;
        case (pat)
            PH_0:     r.idx = 3'd0;
            PH_1:     r.idx = 3'd1;
            PH_2:     r.idx = 3'd2;
            PH_3:     r.idx = 3'd3;
            PH_4:     r.idx = 3'd4;
            PH_5:     r.idx = 3'd5;
            PH_6:     r.idx = 3'd6;
            PH_7:     r.idx = 3'd7;
            PAT_IDLE: r.kind = PK_IDLE;
            default:  r.kind = PK_ILLEGAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/coil_phase_decoder_if.sv
// Coil bus monitor signals; step_period exists only with STEP_PERIOD_EN.
interface coil_phase_decoder_if #(
    parameter int POS_W = 16
`ifdef STEP_PERIOD_EN
    , parameter int PER_W = 20
`endif
);
    logic [3:0]              coils;
    logic                    en;
    logic                    fault_clr;
    logic                    step_valid;
    logic                    step_dir;
    logic                    step_half;
    logic signed [POS_W-1:0] position;
    logic                    idle;
    logic                    fault;
    logic [1:0]              fault_code;
`ifdef STEP_PERIOD_EN
    logic [PER_W-1:0]        step_period;

    modport master (
        output coils, en, fault_clr,
        input  step_valid, step_dir, step_half, position,
        input  idle, fault, fault_code, step_period
    );
    modport slave (
        input  coils, en, fault_clr,
        output step_valid, step_dir, step_half, position,
        output idle, fault, fault_code, step_period
    );
`else
    modport master (
        output coils, en, fault_clr,
        input  step_valid, step_dir, step_half, position,
        input  idle, fault, fault_code
    );
    modport slave (
        input  coils, en, fault_clr,
        output step_valid, step_dir, step_half, position,
        output idle, fault, fault_code
    );
`endif
endinterface

// File: rtl/coil_phase_decoder_filter.sv
// Coil pattern synchroniser and stability filter; emits the accepted
// pattern with a one-cycle accept strobe.
module coil_filter #(
    parameter int STABLE_CYC = 4
) (
    input  logic       pulse,
    input  logic       reset,
    input  logic [3:0] coils,
    output logic [3:0] acc_pat,
    output logic       accept
);
    localparam int CW = $clog2(STABLE_CYC + 1);

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept_q, accept_d;

    always_comb begin
        sync1_d  = coils;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        accept_d = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CW'(1);
        end else if (cnt_q != CW'(STABLE_CYC)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CW'(STABLE_CYC) && cand_d != acc_q) begin
            acc_d    = cand_d;
            accept_d = 1'b1;
        end
    end

    always_ff @(posedge pulse) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
        end
    end

    assign acc_pat = acc_q;
    assign accept  = accept_q;

endmodule

// File: rtl/coil_phase_decoder.sv
// Stepper coil monitor: step decode, half-step position and fault flags.
// STEP_PERIOD_EN adds the step_period measurement.
module coil_phase_decoder
    import stepper_pkg::*;
#(
    parameter int POS_W      = 16,
    parameter int STABLE_CYC = 4
`ifdef STEP_PERIOD_EN
    , parameter int PER_W    = 20
`endif
) (
    input  logic                 pulse,
    input  logic                 reset,
    coil_phase_decoder_if.slave  bus
);
    logic [3:0]       acc_pat;
    logic             accept;
    phase_t           ph;
    phase_t           last_q, last_d;
    logic [2:0]       delta;
    logic             step_ev, fwd, two;
    logic             new_fault;
    logic [1:0]       new_code;
    logic [POS_W-1:0] amt;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             valid_q, valid_d;
    logic             dir_q, dir_d;
    logic             half_q, half_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;

    coil_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
        .pulse   (pulse),
        .reset   (reset),
        .coils   (bus.coils),
        .acc_pat (acc_pat),
        .accept  (accept)
    );

    assign ph    = phase_lookup(acc_pat);
    assign delta = ph.idx - last_q.idx;

    always_comb begin
        last_d    = last_q;
        step_ev   = 1'b0;
        fwd       = 1'b0;
        two       = 1'b0;
        new_fault = 1'b0;
        new_code  = FC_NONE;
        if (accept) begin
            unique case (ph.kind)
                PK_ILLEGAL: begin
                    new_fault = 1'b1;
                    new_code  = FC_ILLEGAL;
                    last_d    = PHASE_NONE;
                end
                PK_IDLE: last_d = ph;
                PK_LEGAL: begin
                    last_d = ph;
                    // Coming from NONE/IDLE only re-acquires the phase.
                    if (last_q.kind == PK_LEGAL) begin
                        unique case (delta)
                            3'd1: begin step_ev = 1'b1; fwd = 1'b1; end
                            3'd2: begin step_ev = 1'b1; fwd = 1'b1; two = 1'b1; end
                            3'd7: step_ev = 1'b1;
                            3'd6: begin step_ev = 1'b1; two = 1'b1; end
                            default: begin
                                new_fault = 1'b1;
                                new_code  = FC_SKIP;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        amt     = two ? POS_W'(2) : POS_W'(1);
        pos_d   = pos_q;
        valid_d = 1'b0;
        dir_d   = dir_q;
        half_d  = half_q;
        if (step_ev && bus.en) begin
            valid_d = 1'b1;
            dir_d   = fwd;
            half_d  = ~two;
            pos_d   = fwd ? pos_q + amt : pos_q - amt;
        end
        fault_d = fault_q;
        code_d  = code_q;
        // A new fault beats a simultaneous clear and records its own code.
        if (new_fault) begin
            fault_d = 1'b1;
            if (!fault_q || bus.fault_clr) code_d = new_code;
        end else if (bus.fault_clr) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end
    end

    always_ff @(posedge pulse) begin
        if (reset) begin
            last_q  <= PHASE_NONE;
            pos_q   <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            last_q  <= last_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign bus.step_valid = valid_q;
    assign bus.step_dir   = dir_q;
    assign bus.step_half  = half_q;
    assign bus.position   = pos_q;
    assign bus.idle       = (acc_pat == PAT_IDLE);
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

`ifdef STEP_PERIOD_EN
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             seen_q, seen_d;
    logic             idle_acc;

    assign idle_acc = accept && (ph.kind == PK_IDLE);

    always_comb begin
        per_cnt_d = (&per_cnt_q) ? per_cnt_q : per_cnt_q + 1'b1;
        per_d     = per_q;
        seen_d    = seen_q;
        if (valid_d) begin
            per_cnt_d = '0;
            seen_d    = 1'b1;
            if (seen_q) per_d = (&per_cnt_q) ? per_cnt_q : per_cnt_q + 1'b1;
        end
        if (idle_acc) begin
            per_cnt_d = '0;
            per_d     = '0;
            seen_d    = 1'b0;
        end
    end

    always_ff @(posedge pulse) begin
        if (reset) begin
            per_cnt_q <= '0;
            per_q     <= '0;
            seen_q    <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            per_q     <= per_d;
            seen_q    <= seen_d;
        end
    end

    assign bus.step_period = per_q;
`endif

endmodule

// File: tb/tb_coil_phase_decoder.sv
// Randomised and directed bench for coil_phase_decoder against a
// segment-level behavioural model.
module tb_coil_phase_decoder;

    localparam int S = 4;

    logic pulse = 1'b0;
    logic reset = 1'b1;
    always #5 pulse = ~pulse;

`ifdef STEP_PERIOD_EN
    coil_phase_decoder_if #(.POS_W(16), .PER_W(20)) ia ();
    coil_phase_decoder_if #(.POS_W(4), .PER_W(20)) ib ();
`else
    coil_phase_decoder_if #(.POS_W(16)) ia ();
    coil_phase_decoder_if #(.POS_W(4)) ib ();
`endif

    coil_phase_decoder #(
        .POS_W(16), .STABLE_CYC(S)
`ifdef STEP_PERIOD_EN
        , .PER_W(20)
`endif
    ) dut_a (.pulse(pulse), .reset(reset), .bus(ia.slave));

    coil_phase_decoder #(
        .POS_W(4), .STABLE_CYC(S)
`ifdef STEP_PERIOD_EN
        , .PER_W(20)
`endif
    ) dut_b (.pulse(pulse), .reset(reset), .bus(ib.slave));

    int checks = 0;
    int failures = 0;

    logic [3:0] tbl [8] = '{4'b1000, 4'b0011, 4'b0010, 4'b0110,
                            4'b0100, 4'b1100, 4'b0001, 4'b1001};
    int picks [4] = '{1, 2, 7, 6};

    // Model state; m_last: -1 none, -2 idle, else phase index
    logic [3:0] m_acc;
    int         m_last;
    int         m_pos;
    bit         m_dir, m_half, m_fault;
    int         m_code;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] p);
        if (p == 4'b0000) return -2;
        for (int i = 0; i < 8; i++) if (tbl[i] == p) return i;
        return -3;
    endfunction

    task automatic m_reset();
        m_acc = 4'b0000; m_last = -1; m_pos = 0;
        m_dir = 0; m_half = 0; m_fault = 0; m_code = 0;
    endtask

    task automatic m_clear();
        m_fault = 0; m_code = 0;
    endtask

    task automatic m_raise(input int c);
        if (!m_fault) begin m_fault = 1; m_code = c; end
    endtask

    task automatic m_accept(input logic [3:0] p, input bit en,
                            output bit stepped);
        int n, d;
        stepped = 0;
        if (p == m_acc) return;
        m_acc = p;
        n = idx_of(p);
        if (n == -3) begin
            m_raise(1); m_last = -1;
        end else if (n == -2) begin
            m_last = -2;
        end else if (m_last < 0) begin
            m_last = n;
        end else begin
            d = (n - m_last + 8) % 8;
            if (d >= 3 && d <= 5) m_raise(2);
            else if (en) begin
                stepped = 1;
                m_dir = (d <= 2);
                m_half = (d == 1 || d == 7);
                m_pos += (d == 1) ? 1 : (d == 2) ? 2 : (d == 7) ? -1 : -2;
            end
            m_last = n;
        end
    endtask

    task automatic drive(input logic [3:0] p, input bit en, input bit clr);
        ia.coils = p; ib.coils = p;
        ia.en = en; ib.en = en;
        ia.fault_clr = clr; ib.fault_clr = clr;
    endtask

    task automatic set_clr(input bit clr);
        ia.fault_clr = clr; ib.fault_clr = clr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b0000, 1'b1, 1'b0);
        repeat (3) @(posedge pulse);
        #1 reset = 1'b0;
        m_reset();
    endtask

    // clr_at: edge (counted from the main change) at which fault_clr is high
    task automatic run_seg(input logic [3:0] p, input bit en, input int clr_at,
                           input int glen, input logic [3:0] gp,
                           input int hold, input string tag);
        int lat, nsv;
        bit st;
        lat = -1; nsv = 0;
        if (glen > 0) begin
            drive(gp, en, 1'b0);
            repeat (glen) @(posedge pulse);
            #1;
        end
        drive(p, en, clr_at == 1);
        for (int k = 1; k <= hold; k++) begin
            @(posedge pulse);
            #1;
            set_clr(k + 1 == clr_at);
            if (ia.step_valid === 1'b1) begin
                nsv++;
                if (lat < 0) lat = k;
            end
        end
        if (clr_at > 0 && clr_at <= S + 3) m_clear();
        m_accept(p, en, st);
        if (clr_at > S + 3) m_clear();
        chk({tag, ":steps"}, nsv, st);
        if (st) chk({tag, ":lat"}, lat, S + 3);
        chk({tag, ":pos"}, {16'h0, ia.position}, m_pos & 32'hFFFF);
        chk({tag, ":pos4"}, {28'h0, ib.position}, m_pos & 32'hF);
        chk({tag, ":dir"}, ia.step_dir, m_dir);
        chk({tag, ":half"}, ia.step_half, m_half);
        chk({tag, ":fault"}, ia.fault, m_fault);
        chk({tag, ":code"}, ia.fault_code, m_code);
        chk({tag, ":idle"}, ia.idle, m_acc == 4'b0000);
    endtask

    initial begin
        logic [3:0] p, gp;
        int r, glen, clr_at, hold;
        bit en;

        drive(4'b0000, 1'b1, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge pulse);
        #1;
        chk("rst:valid", ia.step_valid, 0);
        chk("rst:idle", ia.idle, 1);
        chk("rst:pos", {16'h0, ia.position}, 0);
        chk("rst:fault", ia.fault, 0);
        chk("rst:code", ia.fault_code, 0);
        chk("rst:dir", ia.step_dir, 0);
        reset = 1'b0;
        m_reset();

        run_seg(4'b1000, 1, 0, 0, 4'b0, 10, "t1_acq");
        run_seg(4'b0010, 1, 0, 0, 4'b0, 10, "t1_s1");
        run_seg(4'b0100, 1, 0, 0, 4'b0, 10, "t1_s2");
        run_seg(4'b0001, 1, 0, 0, 4'b0, 10, "t1_s3");
        run_seg(4'b1000, 1, 0, 0, 4'b0, 10, "t1_s4");
        chk("t1_pos8", {16'h0, ia.position}, 8);

        do_reset();
        run_seg(4'b1000, 1, 0, 0, 4'b0, 10, "t2_acq");
        run_seg(4'b1001, 1, 0, 0, 4'b0, 10, "t2_s1");
        run_seg(4'b0001, 1, 0, 0, 4'b0, 10, "t2_s2");
        run_seg(4'b1100, 1, 0, 0, 4'b0, 10, "t2_s3");
        chk("t2_posm3", {16'h0, ia.position}, 32'hFFFD);

        do_reset();
        run_seg(4'b1000, 1, 0, 0, 4'b0, 10, "t3_acq");
        run_seg(4'b1000, 1, 0, 1, 4'b0010, 10, "t3_glitch");

        run_seg(4'b0100, 1, 0, 0, 4'b0, 10, "t4_skip");
        run_seg(4'b0110, 1, 0, 0, 4'b0, 10, "t4_rev");
        run_seg(4'b0101, 1, 0, 0, 4'b0, 10, "t4_ill");
        chk("t4_code_kept", ia.fault_code, 2);
        run_seg(4'b1111, 1, 1, 0, 4'b0, 10, "t4_clr_ill");
        chk("t4_code_ill", ia.fault_code, 1);
        run_seg(4'b1000, 1, 0, 0, 4'b0, 10, "t4_reacq");
        run_seg(4'b0100, 1, S + 3, 0, 4'b0, 10, "t4_samecyc");
        chk("t4_code_new", ia.fault_code, 2);

        do_reset();
        run_seg(4'b1000, 1, 0, 0, 4'b0, 10, "t5_acq");
        run_seg(4'b0010, 0, 0, 0, 4'b0, 10, "t5_off1");
        run_seg(4'b0100, 0, 0, 0, 4'b0, 10, "t5_off2");
        run_seg(4'b0001, 1, 0, 0, 4'b0, 10, "t5_on");
        chk("t5_pos2", {16'h0, ia.position}, 2);

        drive(4'b0010, 1'b1, 1'b0);
        repeat (2) @(posedge pulse);
        #1 reset = 1'b1;
        @(posedge pulse);
        #1 reset = 1'b0;
        m_reset();
        run_seg(4'b0010, 1, 0, 0, 4'b0, 10, "t5_rstmid");

        do_reset();
`ifdef STEP_PERIOD_EN
        chk("t6_per_rst", ia.step_period, 0);
`endif
        run_seg(4'b1000, 1, 0, 0, 4'b0, 25, "t6_acq");
        run_seg(4'b0011, 1, 0, 0, 4'b0, 25, "t6_h1");
`ifdef STEP_PERIOD_EN
        chk("t6_per_one", ia.step_period, 0);
`endif
        run_seg(4'b0010, 1, 0, 0, 4'b0, 25, "t6_h2");
`ifdef STEP_PERIOD_EN
        chk("t6_per25", ia.step_period, 25);
`endif
        for (int i = 3; i < 8; i++)
            run_seg(tbl[i], 1, 0, 0, 4'b0, 25, $sformatf("t6_h%0d", i));
        chk("t6_pos7", {28'h0, ib.position}, 7);
        run_seg(4'b1000, 1, 0, 0, 4'b0, 25, "t6_wrap");
        chk("t6_posm8", {28'h0, ib.position}, 4'b1000);

        for (int s = 0; s < 80; s++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                if (m_last >= 0)
                    p = tbl[(m_last + picks[$urandom_range(0, 3)]) % 8];
                else
                    p = tbl[$urandom_range(0, 7)];
            end else if (r == 7) begin
                p = 4'b0000;
            end else begin
                p = 4'($urandom_range(0, 15));
            end
            en = ($urandom_range(0, 4) != 0);
            clr_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, S + 5) : 0;
            gp = 4'($urandom_range(0, 15));
            glen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S - 1) : 0;
            if (gp == p) glen = 0;
            hold = S + 6 + $urandom_range(0, 6);
            run_seg(p, en, clr_at, glen, gp, hold, $sformatf("r%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
